fifo_modport: RTL and testbench
===============================

// Module: fifo_modport
// PURPOSE
//  Synchronous single-clock FIFO between a write-side producer (master driver) and a
//  read-side consumer (slave driver); a passive monitor observes every port.
//  Buffers FIFO_DEPTH words of FIFO_WIDTH bits, presents registered full/empty flags,
//  and returns read data one clock after an accepted read.
// PARAMETERS
//  FIFO_WIDTH  32       data word width in bits
//  FIFO_DEPTH  2**5=32  number of entries; power of two, >= 2
// PORTS
//  clk       in   1           single clock; all state changes on posedge clk
//  rstN      in   1           reset, asynchronous, active-high (1 = reset)
//  wr_en     in   1           write request; data_in is captured when accepted
//  data_in   in   FIFO_WIDTH  write data
//  rd_en     in   1           read request
//  empty     out  1           1 = no stored entries
//  full      out  1           1 = FIFO_DEPTH stored entries
//  data_out  out  FIFO_WIDTH  read data, registered
// BEHAVIOUR
//  - Reset (rstN=1, async assert, sync release at next posedge):
//    wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, data_out=0. Storage array is not reset.
//  - Write accept: wr_en && !full. Store mem[wr_ptr]<=data_in; wr_ptr++ (mod FIFO_DEPTH).
//  - Write while full: ignored; no state change, no error output.
//  - Read accept: rd_en && !empty. data_out<=mem[rd_ptr]; rd_ptr++ (mod FIFO_DEPTH).
//    Read latency: 1 clock; data valid after the accepting edge.
//  - Read while empty: ignored; data_out holds its previous value.
//  - data_out changes only on an accepted read; otherwise holds.
//  - Simultaneous wr_en && rd_en:
//    - Neither full nor empty: both accepted; count unchanged.
//    - Empty: only the write is accepted. No fall-through; data is readable next cycle.
//    - Full: only the read is accepted. The write is dropped even though a slot frees.
//  - count width $clog2(FIFO_DEPTH)+1.
//    count += accepted write, -= accepted read.
//    Range is 0..FIFO_DEPTH; no overflow or underflow is possible.
//  - Flags are registered and computed from next-count:
//    empty = (count_next==0), full = (count_next==FIFO_DEPTH). Both are valid the cycle
//    after the causing edge; never both 1.
//  - Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
//    Ordering is strictly first-in first-out across wraps.
//  - Reset mid-operation: all contents are discarded immediately (async).
//    Flags and data_out take their reset values without waiting for a clock edge.
//  - Inputs are sampled at posedge. Environment drives and samples with a 2 ns skew;
//    the design has no combinational input->output paths.
// STRUCTURE
//  - Package fifo_pkg:
//    - FIFO_WIDTH_DEF=32, FIFO_DEPTH_DEF=32.
//    - Localparam function for pointer width, $clog2(FIFO_DEPTH).
//    - typedef for count.
//  - Sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH dual-port RAM.
//    Write port: we, waddr, wdata. Read port: registered dout on re.
//  - Top level holds pointers, count, flag registers and accept logic.
// TESTING
//  - Reset: assert rstN=1 mid-traffic with no clock edge.
//    -> empty=1, full=0, data_out=0 immediately; a subsequent read returns nothing new.
//  - Fill/drain: write 0x0..0x1F (32 words).
//    -> full=1 after the 32nd write edge.
//    -> A 33rd write of 0xDEAD is dropped.
//    -> 32 reads return 0x0..0x1F in order; empty=1 after the last.
//  - Underflow: from reset, rd_en=1 for 3 cycles.
//    -> empty stays 1, data_out stays 0, count stays 0.
//  - Simultaneous at boundaries:
//    - Empty with wr=rd=1, data 0xA5.
//      -> Write only; empty=0 next cycle; data_out unchanged.
//    - Full with wr=rd=1.
//      -> Read only; full=0 next cycle; the written word is absent from later reads.
//  - Wrap-around: hold count at 16, then do 100 cycles of wr=rd=1 with an incrementing
//    pattern.
//    -> Reads track writes with a 16-word lag and no loss across pointer wrap.
//    -> empty=full=0 throughout.
//  - Random traffic against a queue model.
//    -> data_out, empty and full match the model every cycle; flags are never both 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing for the single-clock FIFO: default geometry and pointer/count widths.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 32;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);

  // One extra bit so the count can represent a completely full FIFO.
  typedef logic [PTR_W_DEF:0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// Depth x Width dual-port storage; one synchronous write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned Width = FIFO_WIDTH_DEF,
  parameter int unsigned Depth = FIFO_DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          we_i,
  input  logic [ptr_width(Depth)-1:0]   waddr_i,
  input  logic [Width-1:0]              wdata_i,
  input  logic                          re_i,
  input  logic [ptr_width(Depth)-1:0]   raddr_i,
  output logic [Width-1:0]              dout_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] dout_q;

  // Storage is deliberately left unreset so it can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (re_i) begin
      dout_q <= mem_q[raddr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/fifo_modport.sv
// Single-clock FIFO top: pointers, occupancy count, registered flags and accept logic.
module fifo_modport
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_WIDTH-1:0] data_out
);

  localparam int unsigned PtrW = ptr_width(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            wr_acc, rd_acc;

  // Accept decisions use the registered flags, so a write while full is dropped
  // even when a simultaneous read frees a slot.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  fifo_mem #(
    .Width (FIFO_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rstN),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .dout_o  (data_out)
  );

  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_fifo_modport.sv
// Randomized and directed bench for fifo_modport against a queue-based reference model.
module tb_fifo_modport;

  localparam int unsigned W = 32;
  localparam int unsigned D = 32;

  logic         clk = 1'b0;
  logic         rstN;
  logic         wr_en;
  logic [W-1:0] data_in;
  logic         rd_en;
  logic         empty;
  logic         full;
  logic [W-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] dout_m;

  always #5 clk = ~clk;

  fifo_modport #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .empty    (empty),
    .full     (full),
    .data_out (data_out)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_dout"}, data_out, dout_m);
    check_eq({tag, "_empty"}, W'(empty), W'(q.size() == 0));
    check_eq({tag, "_full"}, W'(full), W'(q.size() == D));
    check_eq({tag, "_excl"}, W'(empty & full), '0);
  endtask

  // Called at posedge+2: drive, take one edge, update the model, sample at posedge+2.
  task automatic cycle(input string tag, input logic w, input logic [W-1:0] d, input logic r);
    bit ra, wa;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    ra = r && (q.size() != 0);
    wa = w && (q.size() != D);
    if (ra) dout_m = q.pop_front();
    if (wa) q.push_back(d);
    #2;
    check_model(tag);
  endtask

  task automatic model_reset();
    q.delete();
    dout_m = '0;
  endtask

  initial begin
    int wprob;
    logic [W-1:0] exp_w;

    rstN = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    @(posedge clk);
    #2;
    check_eq("reset_empty", W'(empty), W'(1));
    check_eq("reset_full", W'(full), W'(0));
    check_eq("reset_dout", data_out, '0);
    rstN = 1'b0;

    for (int i = 0; i < 3; i++) cycle("underflow", 1'b0, '0, 1'b1);
    check_eq("underflow_dout", data_out, '0);

    cycle("sim_empty", 1'b1, 32'hA5, 1'b1);
    check_eq("sim_empty_not_empty", W'(empty), W'(0));
    check_eq("sim_empty_dout_held", data_out, '0);
    cycle("sim_empty_read", 1'b0, '0, 1'b1);
    check_eq("sim_empty_read_data", data_out, 32'hA5);

    for (int i = 0; i < 32; i++) cycle("fill", 1'b1, W'(i), 1'b0);
    check_eq("fill_full", W'(full), W'(1));
    cycle("overflow", 1'b1, 32'hDEAD, 1'b0);
    cycle("sim_full", 1'b1, 32'hBEEF, 1'b1);
    check_eq("sim_full_data", data_out, '0);
    check_eq("sim_full_cleared", W'(full), W'(0));
    for (int i = 1; i < 32; i++) begin
      cycle("drain", 1'b0, '0, 1'b1);
      check_eq("drain_order", data_out, W'(i));
    end
    check_eq("drain_empty", W'(empty), W'(1));
    cycle("drain_extra", 1'b0, '0, 1'b1);
    check_eq("drain_no_beef", data_out, W'(31));

    for (int i = 0; i < 16; i++) cycle("wrap_prefill", 1'b1, 32'h1000 + W'(i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle("wrap", 1'b1, 32'h2000 + W'(i), 1'b1);
      exp_w = (i < 16) ? 32'h1000 + W'(i) : 32'h2000 + W'(i - 16);
      check_eq("wrap_lag", data_out, exp_w);
      check_eq("wrap_flags", W'({empty, full}), '0);
    end

    for (int i = 0; i < 10; i++) cycle("pre_rst", 1'b1, $urandom, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    #3;
    rstN = 1'b1;
    #1;
    check_eq("async_rst_empty", W'(empty), W'(1));
    check_eq("async_rst_full", W'(full), W'(0));
    check_eq("async_rst_dout", data_out, '0);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    model_reset();
    cycle("post_rst_rd", 1'b0, '0, 1'b1);
    check_eq("post_rst_dout", data_out, '0);

    for (int p = 0; p < 6; p++) begin
      case (p)
        0: wprob = 80;
        1: wprob = 20;
        2: wprob = 50;
        3: wprob = 95;
        4: wprob = 5;
        default: wprob = 50;
      endcase
      for (int i = 0; i < 100; i++) begin
        cycle("random", ($urandom_range(0, 99) < wprob), $urandom,
              ($urandom_range(0, 99) < (100 - wprob)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
